pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) around the main control decoder.
- Keeps shadow copies of destination/source registers for EX, MEM and WB, and generates:
  - load-use stalls
  - branch flushes
  - forwarding selects for the EX-stage ALU operand muxes
  - global freezes while data memory is not ready
- Sits beside the decoder; its outputs drive PC and pipeline-register enable/flush pins.

Parameters:
- REG_AW, 5, register-address width.
- MEM_TIMEOUT, 16, max consecutive not-ready cycles before halting (≥2).
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  ID source register rs.
- id_rt  in  REG_AW  ID source register rt.
- id_uses_rt  in  1  rt is read as an operand (R-type, beq, sw).
- id_dst  in  REG_AW  ID destination register (post-RegDst mux).
- id_regwrite  in  1  RegWrite from the decoder.
- id_memread  in  1  MemRead from the decoder (load).
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_access  in  1  MEM stage holds a load or store.
- mem_ready  in  1  data memory completes this cycle.
- pc_write  out  1  PC enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  zero the IF/ID register.
- idex_bubble  out  1  load NOP control into ID/EX.
- stall_all  out  1  freeze PC and all pipeline registers.
- fwd_a  out  2  ALU operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- fwd_b  out  2  ALU operand B select, same encoding.
- mem_err  out  1  sticky: memory timeout occurred.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset: all shadow valids cleared; FSM=RUN; timeout counter=0; stall_cnt=0; mem_err=0.
  - Output values during and after reset: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, stall_all=0, fwd_a=fwd_b=00.
- Shadow pipeline:
  - EX stage holds {valid, rs, rt, dst, regwrite, memread}; MEM and WB stages hold {valid, dst, regwrite}.
  - Advances every clock unless stall_all=1, in which case all shadow registers hold.
  - The EX entry is captured from the id_* inputs. When idex_bubble=1 it captures valid=0 instead.
- Load-use:
  - lu = id_valid & ex_valid & ex_memread & ex_dst!=0 & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt)).
  - lu=1 → pc_write=0, ifid_write=0, idex_bubble=1, for exactly one cycle per hazard.
- Branch:
  - ex_branch_taken=1 → ifid_flush=1 and idex_bubble=1; pc_write=1.
  - Branch has priority over lu; lu is ignored that cycle.
- Forwarding (combinational):
  - fwd_a=10 if mem_valid & mem_regwrite & mem_dst!=0 & mem_dst==ex_rs.
  - Otherwise fwd_a=01 if the same condition holds on the WB shadow.
  - Otherwise 00. fwd_b is identical, using ex_rt.
  - MEM beats WB. Register $0 is never forwarded.
- Memory FSM, states RUN / MEM_WAIT / HALT:
  - RUN: mem_access & !mem_ready → stall_all=1 this cycle; next state MEM_WAIT, tmo=1.
  - MEM_WAIT: stall_all = !mem_ready.
    - mem_ready → RUN, tmo=0.
    - Else if tmo==MEM_TIMEOUT-1 → HALT and set mem_err.
    - Else tmo++.
  - HALT: stall_all=1 and pc_write=0 permanently; only rst_n exits.
  - While stall_all=1: pc_write=0, ifid_write=0, and ifid_flush and idex_bubble are forced to 0. Branch and lu are re-evaluated after release.
- stall_cnt increments on every cycle where stall_all | lu, and saturates at all-ones.
- Asynchronous reset mid-MEM_WAIT or in HALT returns the block to RUN with the reset values above.

Decomposition:
- Shared package pipe_pkg holds:
  - fwd encoding constants FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01
  - the FSM state enum
  - REG_AW default
  - opcode constants shared with the decoder
- One natural sub-module: forwarding_unit (purely combinational fwd_a/fwd_b from the shadow registers).

Test Plan:
- lw $8 in EX, add $9,$8,$3 in ID:
  - Cycle t: pc_write=0, idex_bubble=1.
  - Cycle t+1: no stall.
  - Cycle t+2: add in EX, fwd_a=01.
- add $8 then sub $9,$8,$8 back-to-back → fwd_a=fwd_b=10. With MEM and WB both writing $8 → 10. With dst=$0 → 00.
- ex_branch_taken=1 in the same cycle as a load-use condition → ifid_flush=1, idex_bubble=1, pc_write=1, and no stall_cnt increment from lu.
- mem_access=1 with mem_ready low for 3 cycles, then high:
  - stall_all high for 3 cycles; shadow registers and forwarding selects frozen.
  - stall_cnt=3; FSM back in RUN.
- MEM_TIMEOUT=16 and mem_ready never asserted → mem_err=1 on the 16th stalled cycle; stall_all stays 1; rst_n pulse clears everything.
- rst_n asserted during MEM_WAIT → all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared constants and types for the 5-stage MIPS pipeline control
//            (forwarding-select encodings, memory-wait FSM states, opcodes).
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Default register-address width (32 architectural registers)
  localparam int REG_AW_DEF = 5;

  // ALU operand source selects driven into the EX-stage operand muxes
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Data-memory wait sequencer states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } mem_state_e;

  // Primary opcodes shared with the main control decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage
`default_nettype wire

// File: rtl/forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module   : forwarding_unit
// Purpose  : Combinational ALU operand forwarding selects from the MEM and WB
//            shadow registers. The newer result (MEM) wins; $0 never forwards.
// Revision : 1.0 - initial release
// ============================================================================
module forwarding_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              i_mem_valid,
  input  logic              i_mem_regwrite,
  input  logic [REG_AW-1:0] i_mem_dst,
  input  logic              i_wb_valid,
  input  logic              i_wb_regwrite,
  input  logic [REG_AW-1:0] i_wb_dst,
  input  logic [REG_AW-1:0] i_ex_rs,
  input  logic [REG_AW-1:0] i_ex_rt,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b
);

  logic w_mem_wr;
  logic w_wb_wr;

  // A stage can only forward if it really writes a non-zero register
  assign w_mem_wr = i_mem_valid & i_mem_regwrite & (i_mem_dst != '0);
  assign w_wb_wr  = i_wb_valid  & i_wb_regwrite  & (i_wb_dst  != '0);

  // Per-operand priority select: MEM result is younger than WB result
  always_comb begin
    o_fwd_a = FWD_RF;
    o_fwd_b = FWD_RF;
    if (w_mem_wr && (i_mem_dst == i_ex_rs))     o_fwd_a = FWD_EXMEM;
    else if (w_wb_wr && (i_wb_dst == i_ex_rs))  o_fwd_a = FWD_MEMWB;
    if (w_mem_wr && (i_mem_dst == i_ex_rt))     o_fwd_b = FWD_EXMEM;
    else if (w_wb_wr && (i_wb_dst == i_ex_rt))  o_fwd_b = FWD_MEMWB;
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Hazard sequencer for the 5-stage MIPS pipeline: load-use stalls,
//            branch flushes, operand forwarding, data-memory wait freezes with
//            timeout halt, and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  input  logic              mem_access,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              stall_all,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int              TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  // Shadow pipeline
  logic              r_ex_valid, r_ex_regwrite, r_ex_memread;
  logic [REG_AW-1:0] r_ex_rs, r_ex_rt, r_ex_dst;
  logic              r_mem_valid, r_mem_regwrite;
  logic [REG_AW-1:0] r_mem_dst;
  logic              r_wb_valid, r_wb_regwrite;
  logic [REG_AW-1:0] r_wb_dst;

  // Memory-wait sequencer
  mem_state_e        r_state, w_state_nxt;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_stall, w_halt_set, w_lu, w_lu_eff, w_branch;

  // Load in EX whose destination is read by the instruction in ID
  assign w_lu = id_valid & r_ex_valid & r_ex_memread & (r_ex_dst != '0) &
                ((r_ex_dst == id_rs) | (id_uses_rt & (r_ex_dst == id_rt)));

  // A freeze suppresses branch/lu actions; branch outranks load-use.
  // Gating with rst_n gives reset-value outputs while reset is held.
  assign w_branch = rst_n & ex_branch_taken & ~w_stall;
  assign w_lu_eff = w_lu & ~ex_branch_taken & ~w_stall;

  assign stall_all   = w_stall;
  assign pc_write    = ~w_stall & ~w_lu_eff;
  assign ifid_write  = ~w_stall & ~w_lu_eff;
  assign ifid_flush  = w_branch;
  assign idex_bubble = w_branch | w_lu_eff;
  assign mem_err     = r_mem_err;
  assign stall_cnt   = r_stall_cnt;

  // Memory-wait next state, timeout count and freeze request
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo;
    w_stall     = 1'b0;
    w_halt_set  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mem_access && !mem_ready) begin
          w_stall     = 1'b1;
          w_state_nxt = ST_MEM_WAIT;
          w_tmo_nxt   = TMO_ONE;
        end
      end
      ST_MEM_WAIT: begin
        w_stall = ~mem_ready;
        if (mem_ready) begin
          w_state_nxt = ST_RUN;
          w_tmo_nxt   = '0;
        end else if (r_tmo == TMO_LAST) begin
          w_state_nxt = ST_HALT;
          w_halt_set  = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TMO_ONE;
        end
      end
      ST_HALT: begin
        w_stall = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_tmo_nxt   = '0;
      end
    endcase
    if (!rst_n) w_stall = 1'b0;
  end

  // Sequencer state, sticky error flag and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_tmo       <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmo   <= w_tmo_nxt;
      if (w_halt_set) r_mem_err <= 1'b1;
      if ((w_stall || w_lu_eff) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Shadow pipeline advance; everything holds while frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_dst       <= '0;
      r_mem_valid    <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_dst      <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_dst       <= '0;
    end else if (!w_stall) begin
      r_ex_valid     <= id_valid & ~idex_bubble;
      r_ex_regwrite  <= id_regwrite;
      r_ex_memread   <= id_memread;
      r_ex_rs        <= id_rs;
      r_ex_rt        <= id_rt;
      r_ex_dst       <= id_dst;
      r_mem_valid    <= r_ex_valid;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_dst      <= r_ex_dst;
      r_wb_valid     <= r_mem_valid;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_dst       <= r_mem_dst;
    end
  end

  forwarding_unit #(
    .REG_AW (REG_AW)
  ) u_fwd (
    .i_mem_valid    (r_mem_valid),
    .i_mem_regwrite (r_mem_regwrite),
    .i_mem_dst      (r_mem_dst),
    .i_wb_valid     (r_wb_valid),
    .i_wb_regwrite  (r_wb_regwrite),
    .i_wb_dst       (r_wb_dst),
    .i_ex_rs        (r_ex_rs),
    .i_ex_rt        (r_ex_rt),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rt, id_regwrite, id_memread;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        ex_branch_taken, mem_access, mem_ready;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, stall_all, mem_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_AW      (5),
    .MEM_TIMEOUT (16),
    .CNT_W       (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_dst          (id_dst),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .ex_branch_taken (ex_branch_taken),
    .mem_access      (mem_access),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .stall_all       (stall_all),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .mem_err         (mem_err),
    .stall_cnt       (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ut, input logic [4:0] dst, input logic rw,
                        input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut;
    id_dst = dst; id_regwrite = rw; id_memread = mr;
  endtask

  // Inputs change just after the falling edge; checks follow 1 time unit later
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    ex_branch_taken = 1'b0;
    mem_access = 1'b0;
    mem_ready  = 1'b1;

    // ---------------- reset values ----------------
    next_cyc(); next_cyc(); #1;
    chk("rst_pc_write",   pc_write,    1);
    chk("rst_ifid_write", ifid_write,  1);
    chk("rst_ifid_flush", ifid_flush,  0);
    chk("rst_idex_bubble",idex_bubble, 0);
    chk("rst_stall_all",  stall_all,   0);
    chk("rst_fwd_a",      fwd_a,       0);
    chk("rst_fwd_b",      fwd_b,       0);
    chk("rst_mem_err",    mem_err,     0);
    chk("rst_stall_cnt",  stall_cnt,   0);
    next_cyc();
    rst_n = 1'b1;

    // ---------------- load-use: lw $8 ; add $9,$8,$3 ----------------
    next_cyc(); set_id(1, 2, 8, 0, 8, 1, 1);
    next_cyc(); set_id(1, 8, 3, 1, 9, 1, 0); #1;
    chk("lu_pc_write",    pc_write,    0);
    chk("lu_ifid_write",  ifid_write,  0);
    chk("lu_idex_bubble", idex_bubble, 1);
    next_cyc(); #1;
    chk("lu1_pc_write",    pc_write,    1);
    chk("lu1_idex_bubble", idex_bubble, 0);
    chk("lu1_stall_cnt",   stall_cnt,   1);
    next_cyc(); set_id(0, 0, 0, 0, 0, 0, 0); #1;
    chk("lu2_fwd_a", fwd_a, 2'b01);
    chk("lu2_fwd_b", fwd_b, 2'b00);

    // ---------------- forwarding ----------------
    next_cyc(); set_id(1, 1, 2, 1, 8, 1, 0);      // add $8,$1,$2
    next_cyc(); set_id(1, 8, 8, 1, 8, 1, 0);      // sub $8,$8,$8
    next_cyc(); set_id(1, 8, 8, 1, 11, 1, 0); #1; // or $11,$8,$8 ; sub in EX
    chk("b2b_fwd_a", fwd_a, 2'b10);
    chk("b2b_fwd_b", fwd_b, 2'b10);
    next_cyc(); set_id(1, 1, 2, 1, 0, 1, 0); #1;  // add $0,$1,$2 ; or in EX
    chk("memwb_fwd_a", fwd_a, 2'b10);
    chk("memwb_fwd_b", fwd_b, 2'b10);
    next_cyc(); set_id(1, 0, 0, 1, 12, 1, 0);     // reads $0 ; add $0 in EX
    next_cyc(); set_id(0, 0, 0, 0, 0, 0, 0); #1;
    chk("r0_fwd_a", fwd_a, 2'b00);
    chk("r0_fwd_b", fwd_b, 2'b00);
    chk("r0_pc_write", pc_write, 1);

    // ---------------- branch beats load-use ----------------
    next_cyc(); set_id(1, 2, 8, 0, 8, 1, 1);      // lw $8
    next_cyc(); set_id(1, 8, 3, 1, 9, 1, 0); ex_branch_taken = 1'b1; #1;
    chk("br_ifid_flush",  ifid_flush,  1);
    chk("br_idex_bubble", idex_bubble, 1);
    chk("br_pc_write",    pc_write,    1);
    next_cyc(); set_id(0, 0, 0, 0, 0, 0, 0); ex_branch_taken = 1'b0; #1;
    chk("br_stall_cnt",   stall_cnt,   1);
    chk("br_flush_clear", ifid_flush,  0);

    // ---------------- memory wait of 3 cycles ----------------
    do_reset();
    set_id(1, 1, 2, 1, 8, 1, 0);                  // X1: writes $8
    next_cyc(); set_id(1, 8, 8, 1, 9, 1, 0);      // X2: reads $8
    next_cyc(); set_id(1, 3, 4, 1, 5, 1, 0);
    mem_access = 1'b1; mem_ready = 1'b0; #1;
    chk("mw1_stall_all",  stall_all,  1);
    chk("mw1_pc_write",   pc_write,   0);
    chk("mw1_ifid_write", ifid_write, 0);
    chk("mw1_fwd_a",      fwd_a,      2'b10);
    next_cyc(); #1;
    chk("mw2_stall_all",  stall_all,  1);
    chk("mw2_fwd_b",      fwd_b,      2'b10);
    next_cyc(); #1;
    chk("mw3_stall_all",  stall_all,  1);
    chk("mw3_fwd_a",      fwd_a,      2'b10);
    next_cyc(); mem_ready = 1'b1; #1;
    chk("mw4_stall_all",  stall_all,  0);
    chk("mw4_fwd_a",      fwd_a,      2'b10);
    chk("mw4_fwd_b",      fwd_b,      2'b10);
    chk("mw4_stall_cnt",  stall_cnt,  3);
    next_cyc(); set_id(0, 0, 0, 0, 0, 0, 0);
    mem_access = 1'b0; mem_ready = 1'b0; #1;
    chk("mw5_run_state",  stall_all,  0);
    chk("mw5_fwd_a",      fwd_a,      2'b00);
    chk("mw5_stall_cnt",  stall_cnt,  3);

    // ---------------- timeout to HALT ----------------
    next_cyc(); mem_access = 1'b1; mem_ready = 1'b0; #1;
    chk("to1_stall_all", stall_all, 1);
    for (int i = 0; i < 15; i++) next_cyc();
    #1;
    chk("to16_mem_err",   mem_err,   0);
    chk("to16_stall_all", stall_all, 1);
    next_cyc(); #1;
    chk("to17_mem_err",   mem_err,   1);
    next_cyc(); mem_access = 1'b0; mem_ready = 1'b1; #1;
    chk("halt_stall_all", stall_all, 1);
    chk("halt_pc_write",  pc_write,  0);
    chk("halt_stall_cnt", stall_cnt, 20);
    next_cyc(); #1;
    chk("halt2_stall_all", stall_all, 1);
    chk("halt2_mem_err",   mem_err,   1);
    #1 rst_n = 1'b0; #1;
    chk("hrst_mem_err",   mem_err,   0);
    chk("hrst_stall_all", stall_all, 0);
    chk("hrst_pc_write",  pc_write,  1);
    chk("hrst_stall_cnt", stall_cnt, 0);
    next_cyc(); rst_n = 1'b1;

    // ---------------- async reset during MEM_WAIT ----------------
    next_cyc(); mem_access = 1'b1; mem_ready = 1'b0;
    next_cyc(); #1;
    chk("ar_pre_stall_all", stall_all, 1);
    chk("ar_pre_stall_cnt", stall_cnt, 1);
    #1 rst_n = 1'b0; #1;
    chk("ar_stall_all",  stall_all,  0);
    chk("ar_pc_write",   pc_write,   1);
    chk("ar_ifid_write", ifid_write, 1);
    chk("ar_stall_cnt",  stall_cnt,  0);
    next_cyc(); rst_n = 1'b1; mem_access = 1'b0; mem_ready = 1'b0;
    next_cyc(); #1;
    chk("ar_post_run", stall_all, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
